// File: rtl/if_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared types and constants for the instruction-fetch bridge.
//   - if_state_t   : fetch FSM states (IDLE/WAIT/HOLD/DROP)
//   - if_excpt_t   : exception codes reported alongside a delivered word
//   - INST_ADDR_W / INST_W / ZERO_WORD : bus widths and the all-zero word
//   - is_aligned() : word-alignment test for a fetch address
// ---------------------------------------------------------------------------
package if_fetch_unit_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic [INST_W-1:0] ZERO_WORD = '0;

    // Fetch FSM states
    typedef enum logic [1:0] {
        IF_IDLE = 2'b00,
        IF_WAIT = 2'b01,
        IF_HOLD = 2'b10,
        IF_DROP = 2'b11
    } if_state_t;

    // Exception codes carried with a delivered instruction
    typedef enum logic [1:0] {
        EXCPT_NONE    = 2'b00,
        EXCPT_ADEL    = 2'b01,
        EXCPT_TIMEOUT = 2'b10
    } if_excpt_t;

    // Instruction fetches must be word aligned
    function automatic logic is_aligned(input logic [INST_ADDR_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Bridge between the PC register and the IF/ID pipeline register. Issues a
// req/ack transaction to instruction memory for each enabled, aligned pc,
// captures the returned word and hands a registered pc/instruction pair with
// a one-cycle valid pulse to decode. Misaligned pcs and bus timeouts produce
// a NOP_INST delivery tagged with an exception code.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   pc, ce            fetch address and enable from the PC register
//   stall_id          decode stage cannot accept a new instruction
//   flush             discard in-flight and buffered fetches
//   ibus_req/addr     registered bus request and address
//   ibus_ack/rdata    bus acknowledge with same-cycle read data
//   stallreq_if       combinational hold request for the PC register
//   if_pc/inst/valid  registered delivery to the IF/ID register
//   if_excpt          00 none, 01 misaligned (AdEL), 10 bus timeout
// ---------------------------------------------------------------------------
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned        TIMEOUT_CYCLES = 255,
    parameter logic [INST_W-1:0]  NOP_INST       = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INST_ADDR_W-1:0] pc,
    input  logic                   ce,
    input  logic                   stall_id,
    input  logic                   flush,
    output logic                   ibus_req,
    output logic [INST_ADDR_W-1:0] ibus_addr,
    input  logic                   ibus_ack,
    input  logic [INST_W-1:0]      ibus_rdata,
    output logic                   stallreq_if,
    output logic [INST_ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0]      if_inst,
    output logic                   if_valid,
    output logic [1:0]             if_excpt
);

    // Last counter value before a no-ack wait is declared a timeout
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    if_state_t               state;
    logic [15:0]             wait_cnt;
    logic [INST_ADDR_W-1:0]  hold_pc;
    logic [INST_W-1:0]       hold_inst;
    logic                    timeout_hit;
    logic                    deliver_next;

    // >= rather than == so that a flush arriving on the final wait cycle,
    // which bumps the counter past TIMEOUT_LAST, still expires in DROP.
    assign timeout_hit = (wait_cnt >= TIMEOUT_LAST);

    // Decide whether the coming edge produces a delivery; flush and reset
    // both suppress any delivery.
    always_comb begin
        deliver_next = 1'b0;
        if (!rst && !flush) begin
            case (state)
                IF_IDLE: deliver_next = ce && !is_aligned(pc);
                IF_WAIT: deliver_next = ibus_ack ? !stall_id : timeout_hit;
                IF_HOLD: deliver_next = !stall_id;
                default: deliver_next = 1'b0;
            endcase
        end
    end

    // Hold the PC register until the current fetch is about to be handed over
    assign stallreq_if = ce & ~deliver_next;

    // Fetch FSM with registered bus and delivery outputs. if_valid defaults
    // low each cycle so it only ever pulses for one cycle per delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IF_IDLE;
            ibus_req  <= 1'b0;
            ibus_addr <= '0;
            if_pc     <= '0;
            if_inst   <= ZERO_WORD;
            if_valid  <= 1'b0;
            if_excpt  <= EXCPT_NONE;
            wait_cnt  <= '0;
            hold_pc   <= '0;
            hold_inst <= ZERO_WORD;
        end else begin
            if_valid <= 1'b0;
            case (state)
                IF_IDLE: begin
                    if (!flush && ce) begin
                        if (is_aligned(pc)) begin
                            ibus_req  <= 1'b1;
                            ibus_addr <= pc;
                            wait_cnt  <= '0;
                            state     <= IF_WAIT;
                        end else begin
                            if_valid <= 1'b1;
                            if_pc    <= pc;
                            if_inst  <= NOP_INST;
                            if_excpt <= EXCPT_ADEL;
                        end
                    end
                end
                IF_WAIT: begin
                    if (ibus_ack) begin
                        ibus_req <= 1'b0;
                        if (flush) begin
                            state <= IF_IDLE;
                        end else if (stall_id) begin
                            hold_pc   <= ibus_addr;
                            hold_inst <= ibus_rdata;
                            state     <= IF_HOLD;
                        end else begin
                            if_valid <= 1'b1;
                            if_pc    <= ibus_addr;
                            if_inst  <= ibus_rdata;
                            if_excpt <= EXCPT_NONE;
                            state    <= IF_IDLE;
                        end
                    end else if (flush) begin
                        // Request must stay up until the bus answers
                        wait_cnt <= wait_cnt + 16'd1;
                        state    <= IF_DROP;
                    end else if (timeout_hit) begin
                        ibus_req <= 1'b0;
                        if_valid <= 1'b1;
                        if_pc    <= ibus_addr;
                        if_inst  <= NOP_INST;
                        if_excpt <= EXCPT_TIMEOUT;
                        state    <= IF_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                IF_HOLD: begin
                    if (flush) begin
                        state <= IF_IDLE;
                    end else if (!stall_id) begin
                        if_valid <= 1'b1;
                        if_pc    <= hold_pc;
                        if_inst  <= hold_inst;
                        if_excpt <= EXCPT_NONE;
                        state    <= IF_IDLE;
                    end
                end
                IF_DROP: begin
                    // Flushed fetch: swallow the answer or give up silently
                    if (ibus_ack || timeout_hit) begin
                        ibus_req <= 1'b0;
                        state    <= IF_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: state <= IF_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Self-checking bench for if_fetch_unit: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference
// model that tracks the outstanding fetch with plain flags and counters.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam int          T   = 4;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, ce, stall_id, flush, ibus_ack;
    logic [31:0] pc, ibus_rdata;
    logic        ibus_req, stallreq_if, if_valid;
    logic [31:0] ibus_addr, if_pc, if_inst;
    logic [1:0]  if_excpt;

    int checks = 0;
    int errors = 0;

    // Reference model: what the bus and decode interface should look like
    bit          mBusy, mDiscard, mHeld, mDeliver;
    int          mAge;
    logic [31:0] mAddr, mHeldPc, mHeldInst;
    logic        eReq, eValid;
    logic [31:0] eAddr, ePc, eInst;
    logic [1:0]  eExcpt;

    if_fetch_unit #(.TIMEOUT_CYCLES(T), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .pc(pc), .ce(ce), .stall_id(stall_id),
        .flush(flush), .ibus_req(ibus_req), .ibus_addr(ibus_addr),
        .ibus_ack(ibus_ack), .ibus_rdata(ibus_rdata),
        .stallreq_if(stallreq_if), .if_pc(if_pc), .if_inst(if_inst),
        .if_valid(if_valid), .if_excpt(if_excpt)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Record a hand-over to decode in the model
    task automatic modelDeliver(input logic [31:0] p, input logic [31:0] i,
                                input logic [1:0] x);
        mDeliver = 1'b1;
        eValid   = 1'b1;
        ePc      = p;
        eInst    = i;
        eExcpt   = x;
    endtask

    // Advance the model by one clock using the currently driven inputs
    task automatic modelStep();
        mDeliver = 1'b0;
        eValid   = 1'b0;
        if (rst) begin
            mBusy = 0; mDiscard = 0; mHeld = 0; mAge = 0;
            eReq = 0; eAddr = 0; ePc = 0; eInst = 0; eExcpt = 0;
        end else if (mHeld) begin
            if (flush) mHeld = 0;
            else if (!stall_id) begin
                modelDeliver(mHeldPc, mHeldInst, 2'b00);
                mHeld = 0;
            end
        end else if (mBusy) begin
            if (ibus_ack) begin
                mBusy = 0;
                eReq  = 0;
                if (!(mDiscard || flush)) begin
                    if (stall_id) begin
                        mHeld = 1; mHeldPc = mAddr; mHeldInst = ibus_rdata;
                    end else begin
                        modelDeliver(mAddr, ibus_rdata, 2'b00);
                    end
                end
                mDiscard = 0;
            end else if (flush && !mDiscard) begin
                mDiscard = 1;
                mAge++;
            end else if (mAge >= T - 1) begin
                mBusy = 0;
                eReq  = 0;
                if (!mDiscard) modelDeliver(mAddr, NOP, 2'b10);
                mDiscard = 0;
            end else begin
                mAge++;
            end
        end else if (!flush && ce) begin
            if (pc[1:0] != 2'b00) modelDeliver(pc, NOP, 2'b01);
            else begin
                mBusy = 1; eReq = 1; mAddr = pc; eAddr = pc; mAge = 0;
            end
        end
    endtask

    // Drive one cycle of inputs (called at a falling edge), check the
    // combinational stall request, clock once and check registered outputs.
    task automatic applyStimulus(input logic r, input logic c, input logic [31:0] p,
                                 input logic s, input logic f, input logic a,
                                 input logic [31:0] d);
        rst = r; ce = c; pc = p; stall_id = s; flush = f;
        ibus_ack = a; ibus_rdata = d;
        #1;
        modelStep();
        checkOutput("stallreq_if", {31'b0, stallreq_if}, {31'b0, ce & ~mDeliver});
        @(posedge clk);
        @(negedge clk);
        checkOutput("ibus_req", {31'b0, ibus_req}, {31'b0, eReq});
        if (eReq) checkOutput("ibus_addr", ibus_addr, eAddr);
        checkOutput("if_valid", {31'b0, if_valid}, {31'b0, eValid});
        if (eValid) begin
            checkOutput("if_pc", if_pc, ePc);
            checkOutput("if_inst", if_inst, eInst);
            checkOutput("if_excpt", {30'b0, if_excpt}, {30'b0, eExcpt});
        end
    endtask

    initial begin
        logic        r, c, s, f, a;
        logic [31:0] p, d;

        rst = 1; ce = 0; pc = 0; stall_id = 0; flush = 0;
        ibus_ack = 0; ibus_rdata = 0;
        @(negedge clk);

        // Reset state
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("reset ibus_addr", ibus_addr, 32'h0);
        checkOutput("reset if_pc", if_pc, 32'h0);
        checkOutput("reset if_inst", if_inst, 32'h0);
        checkOutput("reset if_excpt", {30'b0, if_excpt}, 32'h0);

        // Single fetch with ack in the first request cycle
        applyStimulus(0, 1, 32'h0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h0, 0, 0, 1, 32'h3401_0001);
        checkOutput("single valid", {31'b0, if_valid}, 32'h1);
        checkOutput("single inst", if_inst, 32'h3401_0001);
        checkOutput("single pc", if_pc, 32'h0);
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 0);

        // Three wait states; address must stay put
        applyStimulus(0, 1, 32'h10, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 32'h10, 0, 0, 0, 0);
            checkOutput("wait addr stable", ibus_addr, 32'h10);
        end
        applyStimulus(0, 1, 32'h10, 0, 0, 1, 32'h8C22_0004);
        checkOutput("wait inst", if_inst, 32'h8C22_0004);
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 0);

        // Decode stall during ack, released two cycles later
        applyStimulus(0, 1, 32'h20, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h20, 1, 0, 1, 32'hAABB_CCDD);
        applyStimulus(0, 1, 32'h20, 1, 0, 0, 0);
        applyStimulus(0, 1, 32'h20, 1, 0, 0, 0);
        checkOutput("hold no valid", {31'b0, if_valid}, 32'h0);
        applyStimulus(0, 0, 32'h20, 0, 0, 0, 0);
        checkOutput("hold release pc", if_pc, 32'h20);
        checkOutput("hold release inst", if_inst, 32'hAABB_CCDD);
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 0);

        // Flush mid-fetch, ack two cycles after the flush
        applyStimulus(0, 1, 32'h30, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h30, 0, 1, 0, 0);
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 0);
        checkOutput("drop req held", {31'b0, ibus_req}, 32'h1);
        applyStimulus(0, 0, 32'h0, 0, 0, 1, 32'hDEAD_BEEF);
        applyStimulus(0, 1, 32'h40, 0, 0, 0, 0);
        checkOutput("new fetch addr", ibus_addr, 32'h40);
        applyStimulus(0, 0, 32'h40, 0, 0, 1, 32'h1234_5678);
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 0);

        // Misaligned pc
        applyStimulus(0, 1, 32'h6, 0, 0, 0, 0);
        checkOutput("adel excpt", {30'b0, if_excpt}, 32'h1);
        checkOutput("adel no req", {31'b0, ibus_req}, 32'h0);
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 0);

        // Bus timeout after T wait cycles
        applyStimulus(0, 1, 32'h50, 0, 0, 0, 0);
        for (int i = 0; i < T; i++) applyStimulus(0, 0, 32'h0, 0, 0, 0, 0);
        checkOutput("timeout excpt", {30'b0, if_excpt}, 32'h2);
        checkOutput("timeout req low", {31'b0, ibus_req}, 32'h0);
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 0);

        // Reset mid-WAIT, then a late ack that must be ignored
        applyStimulus(0, 1, 32'h60, 0, 0, 0, 0);
        applyStimulus(0, 0, 32'h0, 0, 0, 0, 0);
        applyStimulus(1, 0, 32'h0, 0, 0, 1, 32'hFFFF_FFFF);
        checkOutput("rst mid req", {31'b0, ibus_req}, 32'h0);
        checkOutput("rst mid pc", if_pc, 32'h0);
        applyStimulus(0, 0, 32'h0, 0, 0, 1, 32'hFFFF_FFFF);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(99) < 2);
            c = ($urandom_range(99) < 80);
            p = $urandom;
            if ($urandom_range(7) != 0) p[1:0] = 2'b00;
            s = ($urandom_range(99) < 30);
            f = ($urandom_range(99) < 8);
            a = mBusy ? ($urandom_range(99) < 35) : ($urandom_range(99) < 5);
            d = $urandom;
            applyStimulus(r, c, p, s, f, a, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
